// File: rtl/f_fetch_pkg.sv
// Shared definitions for the fetch stage: reset PC, legal instruction-memory
// window, the nop encoding and the fetch FSM state type.
// The address-window helper is only referenced when FETCH_ADEL_EN is defined.
package f_fetch_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // request pc from instruction memory
        ST_WAIT = 2'd1,  // granted, waiting for the response
        ST_HOLD = 2'd2   // instruction held until IF/ID takes it
    } fetch_state_e;

    // True when a fetch address is misaligned or outside instruction memory.
    function automatic logic addr_illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
    endfunction

endpackage

// File: rtl/f_fetch_npc.sv
// Combinational next-pc select for the fetch stage.
// A redirect arriving in the consume cycle beats an older pending target,
// which in turn beats sequential pc+4. All arithmetic wraps modulo 2^32.
// Optional: FETCH_ADEL_EN enables the fetch address-error check on pc.
module fetch_npc
    import f_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        pend_valid_i,
    input  logic [31:0] pend_tgt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] npc_o,
    output logic [31:0] pc_plus8_o,
    output logic        addr_err_o
);

    // Priority select of the pc used after the held instruction is consumed.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        npc_o = pc_i + 32'd4;
        if (redirect_i) begin
            npc_o = redirect_target_i;
        end else if (pend_valid_i) begin
            npc_o = pend_tgt_i;
        end
    end

    assign pc_plus8_o = pc_i + 32'd8;

`ifdef FETCH_ADEL_EN
    assign addr_err_o = addr_illegal(pc_i);
`else
    assign addr_err_o = 1'b0;
`endif

endmodule

// File: rtl/f_fetch.sv
// Fetch stage feeding the IF/ID register. Owns the PC, issues one outstanding
// req/gnt/rvalid transaction at a time and holds the returned instruction
// until IF/ID consumes it. Redirects are queued and applied only after the
// delay-slot instruction in flight has been delivered and consumed.
// Optional: FETCH_ADEL_EN turns illegal fetch addresses into a held nop with
// F_adel=1 instead of a memory request.
module f_fetch
    import f_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        F_valid,
    output logic [31:0] F_Instr,
    output logic [31:0] F_PC,
    output logic [31:0] F_PC8,
    output logic        F_adel
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q;
    logic        pend_valid_q;
    logic [31:0] pend_tgt_q;
    logic        req_en_q;     // low for the first cycle after reset release
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] fpc_q;
    logic [31:0] fpc8_q;
    logic        adel_q;

    logic [31:0] npc;
    logic [31:0] pc_plus8;
    logic        addr_err;
    logic        consume;
    logic        resp_take;
    logic        adel_take;

    fetch_npc u_npc (
        .pc_i              (pc_q),
        .pend_valid_i      (pend_valid_q),
        .pend_tgt_i        (pend_tgt_q),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .npc_o             (npc),
        .pc_plus8_o        (pc_plus8),
        .addr_err_o        (addr_err)
    );

    assign consume   = (state_q == ST_HOLD) && WE;
    assign resp_take = (state_q == ST_WAIT) && im_rvalid;
    assign adel_take = (state_q == ST_REQ) && req_en_q && addr_err;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; rvalid is deliberately ignored outside WAIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (req_en_q) begin
                    if (addr_err) begin
                        state_d = ST_HOLD;
                    end else if (im_gnt) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (im_rvalid) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (WE) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // FSM outputs: request only in REQ, address is the (stable) pc.
    always_comb begin
        im_req  = (state_q == ST_REQ) && req_en_q && !addr_err;
        im_addr = pc_q;
    end

    // PC, pending redirect and request-enable registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= PC_RESET;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= 32'h0;
            req_en_q     <= 1'b0;
        end else begin
            req_en_q <= 1'b1;
            if (consume) begin
                pc_q         <= npc;
                pend_valid_q <= 1'b0;
            end else if (redirect) begin
                pend_valid_q <= 1'b1;
                pend_tgt_q   <= redirect_target;
            end
        end
    end

    // Held instruction registers presented to IF/ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            fpc_q   <= 32'h0;
            fpc8_q  <= 32'h0;
            adel_q  <= 1'b0;
        end else if (resp_take) begin
            valid_q <= 1'b1;
            instr_q <= im_rdata;
            fpc_q   <= pc_q;
            fpc8_q  <= pc_plus8;
            adel_q  <= 1'b0;
        end else if (adel_take) begin
            valid_q <= 1'b1;
            instr_q <= NOP_INSTR;
            fpc_q   <= pc_q;
            fpc8_q  <= pc_plus8;
            adel_q  <= 1'b1;
        end else if (consume) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            adel_q  <= 1'b0;
        end
    end

    assign F_valid = valid_q;
    assign F_Instr = instr_q;
    assign F_PC    = fpc_q;
    assign F_PC8   = fpc8_q;
    assign F_adel  = adel_q;

endmodule

// File: tb/tb_f_fetch.sv
// Directed bench for f_fetch: a table of straight-line fetches followed by
// hand-written redirect, stall, wrap, mid-transaction reset and address-error
// sequences. Inputs are driven and outputs sampled on the falling edge.
module tb_f_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        F_valid;
    logic [31:0] F_Instr;
    logic [31:0] F_PC;
    logic [31:0] F_PC8;
    logic        F_adel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    f_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .WE              (WE),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .im_req          (im_req),
        .im_addr         (im_addr),
        .im_gnt          (im_gnt),
        .im_rvalid       (im_rvalid),
        .im_rdata        (im_rdata),
        .F_valid         (F_valid),
        .F_Instr         (F_Instr),
        .F_PC            (F_PC),
        .F_PC8           (F_PC8),
        .F_adel          (F_adel)
    );

    typedef struct {
        int          gnt_wait;
        int          hold;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc8;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Held-instruction outputs for a normally delivered instruction.
    task automatic check_f(input string nm, input logic [31:0] pc, input logic [31:0] pc8,
                           input logic [31:0] instr);
        check({nm, ".F_valid"}, {31'h0, F_valid}, 32'h1);
        check({nm, ".F_Instr"}, F_Instr, instr);
        check({nm, ".F_PC"}, F_PC, pc);
        check({nm, ".F_PC8"}, F_PC8, pc8);
        check({nm, ".F_adel"}, {31'h0, F_adel}, 32'h0);
        check({nm, ".im_req"}, {31'h0, im_req}, 32'h0);
    endtask

    // One memory transaction: expects the request to be up already, optionally
    // stalls the grant (with a redirect at stall cycle redir_at), optionally
    // pulses a redirect in WAIT, then returns rdata one cycle after the grant.
    task automatic do_fetch(input string nm, input logic [31:0] exp_addr, input logic [31:0] rdata,
                            input int gnt_wait, input int redir_at, input logic [31:0] redir_tgt,
                            input bit redir_in_wait);
        int waited = 0;
        while (!im_req && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check({nm, ".req_latency"}, waited, 0);
        if (!im_req) return;
        check({nm, ".im_addr"}, im_addr, exp_addr);
        for (int i = 0; i < gnt_wait; i++) begin
            redirect        = (i == redir_at);
            redirect_target = redir_tgt;
            @(negedge clk);
            redirect = 1'b0;
            check({nm, ".stall_req"}, {31'h0, im_req}, 32'h1);
            check({nm, ".stall_addr"}, im_addr, exp_addr);
        end
        im_gnt = 1'b1;
        @(negedge clk);
        im_gnt = 1'b0;
        check({nm, ".wait_req"}, {31'h0, im_req}, 32'h0);
        check({nm, ".wait_valid"}, {31'h0, F_valid}, 32'h0);
        im_rvalid       = 1'b1;
        im_rdata        = rdata;
        redirect        = redir_in_wait;
        redirect_target = redir_tgt;
        @(negedge clk);
        im_rvalid = 1'b0;
        redirect  = 1'b0;
    endtask

    task automatic consume(input bit with_redir, input logic [31:0] tgt);
        WE              = 1'b1;
        redirect        = with_redir;
        redirect_target = tgt;
        @(negedge clk);
        WE       = 1'b0;
        redirect = 1'b0;
        check("consume.F_valid", {31'h0, F_valid}, 32'h0);
        check("consume.F_Instr", F_Instr, 32'h0);
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect        = 1'b1;
        redirect_target = tgt;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 32'h3C01_0001, 32'h0000_3000, 32'h0000_3008};
        vecs[1] = '{0, 5, 32'h2422_0005, 32'h0000_3004, 32'h0000_300C};
        vecs[2] = '{2, 1, 32'h8C43_0000, 32'h0000_3008, 32'h0000_3010};
        vecs[3] = '{0, 0, 32'hAC44_0004, 32'h0000_300C, 32'h0000_3014};

        reset = 1'b0; WE = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.im_req", {31'h0, im_req}, 32'h0);
        check("rst.F_valid", {31'h0, F_valid}, 32'h0);
        check("rst.F_Instr", F_Instr, 32'h0);
        check("rst.F_PC", F_PC, 32'h0);
        check("rst.F_PC8", F_PC8, 32'h0);
        check("rst.F_adel", {31'h0, F_adel}, 32'h0);
        reset = 1'b1;
        #1 check("release.im_req", {31'h0, im_req}, 32'h0);
        @(negedge clk);
        check("first_edge.im_req", {31'h0, im_req}, 32'h1);

        // Straight-line fetches with grant stalls and IF/ID back-pressure.
        for (int i = 0; i < 4; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].rdata,
                     vecs[i].gnt_wait, -1, 32'h0, 1'b0);
            check_f($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pc8, vecs[i].rdata);
            for (int h = 0; h < vecs[i].hold; h++) begin
                @(negedge clk);
                check("hold.F_PC", F_PC, vecs[i].exp_pc);
                check("hold.F_Instr", F_Instr, vecs[i].rdata);
                check("hold.im_req", {31'h0, im_req}, 32'h0);
            end
            consume(1'b0, 32'h0);
        end

        // Redirect in WAIT: the in-flight instruction is the delay slot.
        do_fetch("dslot", 32'h0000_3010, 32'h1000_0003, 0, -1, 32'h0000_3100, 1'b1);
        check_f("dslot", 32'h0000_3010, 32'h0000_3018, 32'h1000_0003);
        consume(1'b0, 32'h0);
        do_fetch("tgt1", 32'h0000_3100, 32'h0000_0021, 0, -1, 32'h0, 1'b0);
        check_f("tgt1", 32'h0000_3100, 32'h0000_3108, 32'h0000_0021);

        // Two redirects while holding: the later one wins.
        pulse_redirect(32'h0000_3100);
        pulse_redirect(32'h0000_3200);
        check("two_redir.F_PC", F_PC, 32'h0000_3100);
        consume(1'b0, 32'h0);
        do_fetch("tgt2", 32'h0000_3200, 32'h0000_0022, 0, -1, 32'h0, 1'b0);
        check_f("tgt2", 32'h0000_3200, 32'h0000_3208, 32'h0000_0022);

        // Redirect coinciding with consume overrides an older pending target.
        pulse_redirect(32'h0000_3250);
        consume(1'b1, 32'h0000_3300);

        // Grant stalled 4 cycles with a redirect mid-request.
        do_fetch("stall", 32'h0000_3300, 32'h0000_0023, 4, 1, 32'h0000_3400, 1'b0);
        check_f("stall", 32'h0000_3300, 32'h0000_3308, 32'h0000_0023);
        consume(1'b0, 32'h0);
        do_fetch("after_stall", 32'h0000_3400, 32'h0000_0024, 0, -1, 32'h0, 1'b0);
        check_f("after_stall", 32'h0000_3400, 32'h0000_3408, 32'h0000_0024);

`ifndef FETCH_ADEL_EN
        // pc+4 / pc+8 wrap at the top of the address space.
        consume(1'b1, 32'hFFFF_FFFC);
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0025, 0, -1, 32'h0, 1'b0);
        check_f("wrap", 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0025);
        consume(1'b0, 32'h0);
        check("wrap.next_addr", im_addr, 32'h0);
`else
        consume(1'b0, 32'h0);
`endif

        // Reset in WAIT; stale response and gnt+rvalid overlap in REQ ignored.
        im_gnt = 1'b1;
        @(negedge clk);
        im_gnt = 1'b0;
        check("midrst.wait_req", {31'h0, im_req}, 32'h0);
        reset = 1'b0;
        #1;
        check("midrst.F_valid", {31'h0, F_valid}, 32'h0);
        check("midrst.im_req", {31'h0, im_req}, 32'h0);
        @(negedge clk);
        reset     = 1'b1;
        im_rvalid = 1'b1;
        im_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stale.F_valid", {31'h0, F_valid}, 32'h0);
        check("stale.im_req", {31'h0, im_req}, 32'h1);
        check("stale.im_addr", im_addr, 32'h0000_3000);
        im_gnt = 1'b1;
        @(negedge clk);
        im_gnt = 1'b0;
        check("gnt_rv.F_valid", {31'h0, F_valid}, 32'h0);
        check("gnt_rv.im_req", {31'h0, im_req}, 32'h0);
        im_rdata = 32'h3C01_0001;
        @(negedge clk);
        im_rvalid = 1'b0;
        check_f("post_rst", 32'h0000_3000, 32'h0000_3008, 32'h3C01_0001);

        // Misaligned redirect target.
        consume(1'b1, 32'h0000_3002);
`ifdef FETCH_ADEL_EN
        check("adel.im_req", {31'h0, im_req}, 32'h0);
        @(negedge clk);
        check("adel.im_req2", {31'h0, im_req}, 32'h0);
        check("adel.F_valid", {31'h0, F_valid}, 32'h1);
        check("adel.F_adel", {31'h0, F_adel}, 32'h1);
        check("adel.F_Instr", F_Instr, 32'h0);
        check("adel.F_PC", F_PC, 32'h0000_3002);
        check("adel.F_PC8", F_PC8, 32'h0000_300A);
        consume(1'b0, 32'h0);
        check("adel.clear", {31'h0, F_adel}, 32'h0);
`else
        do_fetch("misalign", 32'h0000_3002, 32'h0000_0026, 0, -1, 32'h0, 1'b0);
        check_f("misalign", 32'h0000_3002, 32'h0000_300A, 32'h0000_0026);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
